// File: rtl/pll_seq_pkg.sv
// Shared types and widths for the PLL reset sequencer.
package pll_seq_pkg;

    localparam int STATE_W = 3;
    localparam int RETRY_W = 2;

    typedef enum logic [STATE_W-1:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABILIZE = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } seq_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with asynchronous active-low clear.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Resets the PLL, waits for a stable lock with timeout and bounded retries,
// then releases the core reset; re-sequences on lock loss or relock request.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 742500,
    parameter int MAX_RETRIES         = 3
) (
    input  logic               clk_74a,
    input  logic               reset_n,
    input  logic               pll_locked,
    input  logic               relock_req,
    output logic               pll_rst,
    output logic               core_reset_n,
    output logic               lock_lost,
    output logic               fail,
    output logic [RETRY_W-1:0] retry_count,
    output logic [STATE_W-1:0] seq_state
);

    localparam int MAX_CYC = max3(RST_PULSE_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST   = RETRY_W'(MAX_RETRIES - 1);
    localparam logic [RETRY_W-1:0] RETRY_SAT    = RETRY_W'(MAX_RETRIES);

    seq_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               lock_lost_q, lock_lost_d;
    logic               pll_rst_q, core_reset_n_q, fail_q;
    logic               lk;

    sync_2ff u_lock_sync (
        .clk_i  (clk_74a),
        .rst_ni (reset_n),
        .d_i    (pll_locked),
        .q_o    (lk)
    );

    // relock_req is a single-cycle strobe with no ready: it is acted on in the
    // cycle it is high (outside RESET_PLL) and beats every other transition.
    always_comb begin
        state_d     = state_q;
        retry_d     = retry_q;
        lock_lost_d = 1'b0;

        if (relock_req && (state_q != RESET_PLL)) begin
            state_d = RESET_PLL;
            retry_d = '0;
        end else begin
            case (state_q)
                RESET_PLL: begin
                    if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (lk) begin
                        state_d = STABILIZE;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        if (retry_q == RETRY_LAST) begin
                            state_d = FAIL;
                            retry_d = RETRY_SAT;
                        end else begin
                            state_d = RESET_PLL;
                            retry_d = retry_q + 1'b1;
                        end
                    end
                end
                STABILIZE: begin
                    if (!lk) begin
                        state_d = WAIT_LOCK;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = RUN;
                        retry_d = '0;
                    end
                end
                RUN: begin
                    if (!lk) begin
                        state_d     = RESET_PLL;
                        lock_lost_d = 1'b1;
                    end
                end
                FAIL: begin
                    state_d = FAIL;
                end
                default: begin
                    state_d = RESET_PLL;
                end
            endcase
        end

        // Counter restarts on entry and only runs in states with a terminal count.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if ((state_q == RESET_PLL) || (state_q == WAIT_LOCK) || (state_q == STABILIZE)) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= RESET_PLL;
            cnt_q          <= '0;
            retry_q        <= '0;
            lock_lost_q    <= 1'b0;
            pll_rst_q      <= 1'b1;
            core_reset_n_q <= 1'b0;
            fail_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            retry_q        <= retry_d;
            lock_lost_q    <= lock_lost_d;
            pll_rst_q      <= (state_d == RESET_PLL);
            core_reset_n_q <= (state_d == RUN);
            fail_q         <= (state_d == FAIL);
        end
    end

    assign pll_rst      = pll_rst_q;
    assign core_reset_n = core_reset_n_q;
    assign lock_lost    = lock_lost_q;
    assign fail         = fail_q;
    assign retry_count  = retry_q;
    assign seq_state    = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Event-timeline scoreboard for pll_reset_sequencer: stimulus predicts each output
// edge (cycle, retry count) arithmetically; a negedge monitor matches observed edges.
module tb_pll_reset_sequencer;
    import pll_seq_pkg::*;

    localparam int RST  = 4;
    localparam int STB  = 8;
    localparam int TMO  = 32;
    localparam int MAXR = 2;
    localparam int W    = 32;

    localparam logic [3:0] EV_RST_RISE  = 4'd1;
    localparam logic [3:0] EV_RST_FALL  = 4'd2;
    localparam logic [3:0] EV_CORE_RISE = 4'd3;
    localparam logic [3:0] EV_CORE_FALL = 4'd4;
    localparam logic [3:0] EV_LOST      = 4'd5;
    localparam logic [3:0] EV_FAIL_RISE = 4'd6;
    localparam logic [3:0] EV_FAIL_FALL = 4'd7;

    logic       clk_74a    = 1'b0;
    logic       reset_n    = 1'b0;
    logic       pll_locked = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_rst, core_reset_n, lock_lost, fail;
    logic [1:0] retry_count;
    logic [2:0] seq_state;

    int unsigned cyc;
    int          vectors = 0;
    int          errors  = 0;
    logic [W-1:0] exp_q[$];

    // ---------------- clock / reset / cycle index ----------------
    always #5 clk_74a = ~clk_74a;

    always @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    pll_reset_sequencer #(
        .RST_PULSE_CYCLES    (RST),
        .LOCK_STABLE_CYCLES  (STB),
        .LOCK_TIMEOUT_CYCLES (TMO),
        .MAX_RETRIES         (MAXR)
    ) dut (
        .clk_74a      (clk_74a),
        .reset_n      (reset_n),
        .pll_locked   (pll_locked),
        .relock_req   (relock_req),
        .pll_rst      (pll_rst),
        .core_reset_n (core_reset_n),
        .lock_lost    (lock_lost),
        .fail         (fail),
        .retry_count  (retry_count),
        .seq_state    (seq_state)
    );

    // ---------------- scoreboard helpers ----------------
    function automatic logic [W-1:0] ev(input logic [3:0] k, input int unsigned c, input logic [1:0] r);
        return {k, r, c[25:0]};
    endfunction

    function automatic logic [2:0] ev_state(input logic [3:0] k);
        case (k)
            EV_RST_FALL:  return 3'd1;
            EV_CORE_RISE: return 3'd3;
            EV_FAIL_RISE: return 3'd4;
            default:      return 3'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic observe(input logic [3:0] k);
        logic [W-1:0] got, want;
        got = ev(k, cyc, retry_count);
        vectors++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind=%0d cyc=%0d retry=%0d, required no event",
                     k, cyc, retry_count);
        end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
                errors++;
                $display("FAIL event: got kind=%0d cyc=%0d retry=%0d, required kind=%0d cyc=%0d retry=%0d",
                         got[31:28], got[25:0], got[27:26], want[31:28], want[25:0], want[27:26]);
            end
        end
        check("seq_state_at_event", 32'(seq_state), 32'(ev_state(k)));
    endtask

    // ---------------- monitor ----------------
    logic p_rst, p_core, p_fail, p_lost;

    always @(negedge clk_74a) begin
        if (!reset_n) begin
            p_rst  <= 1'b1;
            p_core <= 1'b0;
            p_fail <= 1'b0;
            p_lost <= 1'b0;
        end else begin
            if (p_lost) check("lock_lost_width", 32'(lock_lost), 32'd0);
            if (pll_rst && !p_rst)       observe(EV_RST_RISE);
            if (!pll_rst && p_rst)       observe(EV_RST_FALL);
            if (core_reset_n && !p_core) observe(EV_CORE_RISE);
            if (!core_reset_n && p_core) observe(EV_CORE_FALL);
            if (lock_lost && !p_lost)    observe(EV_LOST);
            if (fail && !p_fail)         observe(EV_FAIL_RISE);
            if (!fail && p_fail)         observe(EV_FAIL_FALL);
            p_rst  <= pll_rst;
            p_core <= core_reset_n;
            p_fail <= fail;
            p_lost <= lock_lost;
        end
    end

    // ---------------- driver tasks ----------------
    // Returns at the negedge following posedge number c.
    task automatic go_to(input int unsigned c);
        while (cyc < c) @(negedge clk_74a);
    endtask

    // WAIT_LOCK entered at edge e; lock raised after edge p (or already high).
    // Lock is seen 3 edges after being driven; a glitch of one cycle restarts stabilisation.
    task automatic lock_from(input int unsigned e, input int unsigned p, input bit already,
                             input int glitch_off, output int unsigned core_t);
        int unsigned s, x;
        s = already ? e + 1 : (((p + 3) > (e + 1)) ? p + 3 : e + 1);
        x = s + glitch_off;
        core_t = (glitch_off >= 0) ? x + 4 + STB : s + STB;
        exp_q.push_back(ev(EV_CORE_RISE, core_t, 2'd0));
        if (!already) begin
            go_to(p);
            pll_locked = 1'b1;
        end
        if (glitch_off >= 0) begin
            go_to(x);
            pll_locked = 1'b0;
            go_to(x + 1);
            pll_locked = 1'b1;
        end
        go_to(core_t + 2);
    endtask

    // Drop lock while in RUN after edge q; optionally hit relock_req in the cycle lk falls.
    task automatic lose_lock(input int unsigned q, input bit with_relock, output int unsigned e);
        exp_q.push_back(ev(EV_RST_RISE, q + 3, 2'd0));
        exp_q.push_back(ev(EV_CORE_FALL, q + 3, 2'd0));
        if (!with_relock) exp_q.push_back(ev(EV_LOST, q + 3, 2'd0));
        exp_q.push_back(ev(EV_RST_FALL, q + 3 + RST, 2'd0));
        go_to(q);
        pll_locked = 1'b0;
        if (with_relock) begin
            go_to(q + 2);
            relock_req = 1'b1;
            go_to(q + 3);
            relock_req = 1'b0;
        end
        e = q + 3 + RST;
    endtask

    // relock_req in RUN, plus a second request during RESET_PLL that must be ignored.
    task automatic relock_run(input int unsigned c, output int unsigned e);
        exp_q.push_back(ev(EV_RST_RISE, c + 1, 2'd0));
        exp_q.push_back(ev(EV_CORE_FALL, c + 1, 2'd0));
        exp_q.push_back(ev(EV_RST_FALL, c + 1 + RST, 2'd0));
        go_to(c);
        relock_req = 1'b1;
        go_to(c + 1);
        relock_req = 1'b0;
        go_to(c + 2);
        relock_req = 1'b1;
        go_to(c + 3);
        relock_req = 1'b0;
        e = c + 1 + RST;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pll_rst"},      32'(pll_rst),      32'd1);
        check({tag, "_core_reset_n"}, 32'(core_reset_n), 32'd0);
        check({tag, "_lock_lost"},    32'(lock_lost),    32'd0);
        check({tag, "_fail"},         32'(fail),         32'd0);
        check({tag, "_retry_count"},  32'(retry_count),  32'd0);
        check({tag, "_seq_state"},    32'(seq_state),    32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int unsigned e, p, q, t, c, f;
        int unsigned kind;
        int          g;

        repeat (3) @(negedge clk_74a);
        check_reset_values("reset");

        // Power-up sequence with lock 10 cycles after pll_rst falls.
        reset_n = 1'b1;
        exp_q.push_back(ev(EV_RST_FALL, RST, 2'd0));
        e = RST;
        lock_from(e, e + 10, 1'b0, -1, t);

        // Deterministic glitch at stable count 5.
        lose_lock(cyc + 2, 1'b0, e);
        lock_from(e, e + 2, 1'b0, 3, t);

        // Randomized run-mode disturbances.
        for (int i = 0; i < 10; i++) begin
            kind = $urandom_range(0, 2);
            q = cyc + $urandom_range(1, 6);
            g = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 5)) : -1;
            case (kind)
                0: begin
                    lose_lock(q, 1'b0, e);
                    p = $urandom_range(q + 1, e + TMO - 3);
                    lock_from(e, p, 1'b0, g, t);
                end
                1: begin
                    lose_lock(q, 1'b1, e);
                    p = $urandom_range(q + 3, e + TMO - 3);
                    lock_from(e, p, 1'b0, g, t);
                end
                default: begin
                    relock_run(q, e);
                    lock_from(e, 0, 1'b1, g, t);
                end
            endcase
        end

        // Never lock: two timeouts then FAIL with saturated retry count.
        lose_lock(cyc + 2, 1'b0, e);
        exp_q.push_back(ev(EV_RST_RISE, e + TMO, 2'd1));
        exp_q.push_back(ev(EV_RST_FALL, e + TMO + RST, 2'd1));
        f = e + TMO + RST + TMO;
        exp_q.push_back(ev(EV_FAIL_RISE, f, 2'(MAXR)));
        go_to(f + 40);

        // Leave FAIL via relock_req; lock lands exactly on the timeout edge.
        c = cyc;
        exp_q.push_back(ev(EV_RST_RISE, c + 1, 2'd0));
        exp_q.push_back(ev(EV_FAIL_FALL, c + 1, 2'd0));
        exp_q.push_back(ev(EV_RST_FALL, c + 1 + RST, 2'd0));
        relock_req = 1'b1;
        go_to(c + 1);
        relock_req = 1'b0;
        e = c + 1 + RST;
        lock_from(e, e + TMO - 3, 1'b0, -1, t);

        // Asynchronous reset while waiting for lock after one timeout.
        lose_lock(cyc + 3, 1'b0, e);
        exp_q.push_back(ev(EV_RST_RISE, e + TMO, 2'd1));
        exp_q.push_back(ev(EV_RST_FALL, e + TMO + RST, 2'd1));
        go_to(e + TMO + RST + 5);
        check("retry_before_reset", 32'(retry_count), 32'd1);
        reset_n = 1'b0;
        #1;
        check_reset_values("midreset");
        check("queue_empty_at_reset", exp_q.size(), 32'd0);
        repeat (2) @(negedge clk_74a);
        reset_n = 1'b1;
        exp_q.push_back(ev(EV_RST_FALL, RST, 2'd0));
        lock_from(RST, RST + $urandom_range(1, 20), 1'b0, -1, t);

        go_to(cyc + 10);
        check("queue_empty_at_end", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: got timeout at cycle %0d, required completion", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
